sound_request_player: RTL and testbench
=======================================

// Module: sound_request_player
// PURPOSE
//  Consumer side of the game's sound-request lines. Captures request rising edges into
//  pending flags and picks the highest-priority pending sound. Plays that sound as a
//  2-note sequence by driving a freq index and enable into the tone generator (DAC
//  path). Each note and the trailing gap are timed in ms ticks.
// PARAMETERS
//  CLKS_PER_MS  50000  clock cycles per 1 ms tick (50 MHz board clock)
//  NOTE_MS      100    duration of each note, ms
//  GAP_MS       20     silent gap after a sound's last note, ms
// PORTS
//  clk                        in   1  system clock, all logic on posedge
//  resetN                     in   1  asynchronous, active-low reset
//  holeColAudioRequest        in   1  request, priority 0 (highest)
//  ballToBallColAudioRequest  in   1  request, priority 1
//  borderColAudioRequest      in   1  request, priority 2
//  keyEnterAudioRequest       in   1  request, priority 3
//  keyXAudioRequest           in   1  request, priority 4
//  keyYAudioRequest           in   1  request, priority 5 (lowest)
//  soundEnable                out  1  tone generator enable
//  freqIndex                  out  4  tone generator frequency index (0 while disabled)
//  currentSound               out  3  sound_id being played (0 when idle)
//  busy                       out  1  high in PLAY or GAP
// BEHAVIOUR
//  - Reset: all outputs 0, pending flags 0, edge-detect regs 0, FSM=IDLE, counters 0.
//    resetN low mid-sound drops the sound and all pending requests immediately.
//  - Edge capture: req high at edge k, low at edge k-1 -> pending[id] set at edge k.
//    A held level requests once. Several edges before service merge into one (1-bit flag).
//  - FSM IDLE: if any pending at edge k, choose the lowest id and clear its pending bit.
//    Load note 0 and enter PLAY. soundEnable=1 and freqIndex=NOTE_TBL[id][0] after edge k.
//  - Same-edge capture and service: a flag set at edge k is served at edge k+1 (1-cycle latency).
//  - PLAY: stays for exactly NOTE_MS*CLKS_PER_MS cycles per note. The prescaler and ms
//    counter restart on every note and gap entry. After note 0 -> note 1. After note 1
//    -> GAP.
//  - GAP: soundEnable=0, freqIndex=0, busy=1 for GAP_MS*CLKS_PER_MS cycles, then IDLE.
//  - Service in IDLE costs 1 cycle: between GAP end and the next sound there is exactly
//    one cycle with busy=0.
//  - Simultaneous requests: all flags set in the same cycle. They are served one by one
//    in priority order, each played fully.
//  - A request for the sound already playing sets its pending flag. The sound replays
//    once after the current one finishes.
//  - Counters: ms counter width is $clog2(max(NOTE_MS,GAP_MS)+1). Prescaler width is
//    $clog2(CLKS_PER_MS). Both saturate-free: they reload on terminal count.
// CONFIGURATION
//  SOUND_PREEMPT_EN defined: in PLAY or GAP, a pending id lower than currentSound
//  aborts the current sound at the next edge. The aborted sound is dropped, not
//  re-queued. The new sound starts with note 0 in PLAY on that same edge.
//  Not defined: a sound always runs to completion (both notes plus gap).
// STRUCTURE
//  - sound_pkg holds sound_id_t enum and the priority order (HOLE=0, B2B=1, BORDER=2,
//    ENTER=3, KEYX=4, KEYY=5). It also holds the FSM state_t enum (IDLE, PLAY, GAP)
//    and the NOTE_TBL[6][2] 4-bit constant.
//  - NOTE_TBL: {9,4} {11,11} {6,3} {12,7} {8,8} {5,5}.
//  - Sub-module sound_ms_timer: prescaler plus ms counter. Inputs are load and a
//    duration in ms; output is a one-cycle done pulse. It is instantiated once.
// TESTING (CLKS_PER_MS=4, NOTE_MS=3, GAP_MS=1 -> note=12, gap=4 cycles)
//  1 Single 1-cycle holeCol pulse:
//    -> soundEnable=1 for 24 cycles, freqIndex 9 for 12 cycles then 4 for 12 cycles.
//    -> Then 4 cycles enable=0 with busy=1, then busy=0. currentSound=0 throughout.
//  2 All six requests pulsed on the same cycle:
//    -> Sounds play in order 0,1,2,3,4,5, each 28 cycles busy plus 1 idle cycle.
//    -> Total is 6*29 cycles.
//  3 keyX held high for 100 cycles:
//    -> Plays exactly once (freqIndex 8). No second play after release.
//  4 border requested, then border pulsed again 5 cycles into note 0:
//    -> Border plays twice back to back, separated by one idle cycle.
//  5 keyY playing, holeCol pulsed 3 cycles in:
//    -> SOUND_PREEMPT_EN defined: hole starts 1 cycle after its flag sets, and keyY
//       never resumes.
//    -> Not defined: keyY completes and hole follows.
//  6 resetN low for 2 cycles mid-note-1 with enter pending:
//    -> All outputs 0 immediately. After release, stays IDLE with no replay.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and constants for the sound request player: sound ids in
// priority order, the player FSM states and the two-note table per sound.
package sound_pkg;

    localparam int NUM_SOUNDS = 6;

    // Lower id means higher priority.
    typedef enum logic [2:0] {
        SND_HOLE   = 3'd0,
        SND_B2B    = 3'd1,
        SND_BORDER = 3'd2,
        SND_ENTER  = 3'd3,
        SND_KEYX   = 3'd4,
        SND_KEYY   = 3'd5
    } sound_id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Frequency index for note 0 and note 1 of each sound.
    localparam logic [3:0] NOTE_TBL [NUM_SOUNDS][2] = '{
        '{4'd9,  4'd4},
        '{4'd11, 4'd11},
        '{4'd6,  4'd3},
        '{4'd12, 4'd7},
        '{4'd8,  4'd8},
        '{4'd5,  4'd5}
    };

    // Highest-priority (lowest id) set bit. Callers only use the result when
    // at least one bit is set.
    function automatic sound_id_t lowest_pending(input logic [NUM_SOUNDS-1:0] p);
        sound_id_t id;
        id = SND_HOLE;
        for (int i = NUM_SOUNDS - 1; i >= 0; i--) begin
            if (p[i]) id = sound_id_t'(i[2:0]);
        end
        return id;
    endfunction

endpackage

// File: rtl/sound_ms_timer.sv
// Millisecond interval timer: a prescaler divides the clock down to 1 ms
// ticks and an ms counter counts ticks up to a duration latched on load.
// done pulses for one cycle on the last clock cycle of the interval, so a
// load at edge e followed by done yields exactly dur_ms*CLKS_PER_MS cycles.
module sound_ms_timer #(
    parameter int CLKS_PER_MS = 50000,
    parameter int MS_W        = 7
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            load,
    input  logic [MS_W-1:0] dur_ms,
    output logic            done
);

    localparam int PS_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_MS - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic [MS_W-1:0] ms_q, ms_d;
    logic [MS_W-1:0] dur_q, dur_d;
    logic            run_q, run_d;
    logic            ps_tc;

    assign ps_tc = (ps_q == PS_LAST);
    assign done  = run_q && ps_tc && (ms_q == (dur_q - MS_W'(1)));

    // Next-state: load restarts both counters, otherwise count while running
    // and stop after the terminal cycle.
    always_comb begin
        ps_d  = ps_q;
        ms_d  = ms_q;
        dur_d = dur_q;
        run_d = run_q;
        if (load) begin
            ps_d  = '0;
            ms_d  = '0;
            dur_d = dur_ms;
            run_d = 1'b1;
        end else if (run_q) begin
            if (done) begin
                ps_d  = '0;
                ms_d  = '0;
                run_d = 1'b0;
            end else if (ps_tc) begin
                ps_d = '0;
                ms_d = ms_q + MS_W'(1);
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ps_q  <= '0;
            ms_q  <= '0;
            dur_q <= '0;
            run_q <= 1'b0;
        end else begin
            ps_q  <= ps_d;
            ms_q  <= ms_d;
            dur_q <= dur_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/sound_request_player.sv
// Sound request player: latches rising edges of six request lines into
// pending flags, serves the lowest pending id, and plays it as two timed
// notes followed by a silent gap.
// Build option: define SOUND_PREEMPT_EN to let a higher-priority pending
// request abort the sound currently in PLAY or GAP.
module sound_request_player
    import sound_pkg::*;
#(
    parameter int CLKS_PER_MS = 50000,
    parameter int NOTE_MS     = 100,
    parameter int GAP_MS      = 20
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       holeColAudioRequest,
    input  logic       ballToBallColAudioRequest,
    input  logic       borderColAudioRequest,
    input  logic       keyEnterAudioRequest,
    input  logic       keyXAudioRequest,
    input  logic       keyYAudioRequest,
    output logic       soundEnable,
    output logic [3:0] freqIndex,
    output logic [2:0] currentSound,
    output logic       busy
);

    localparam int MAX_MS = (NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS;
    localparam int MS_W   = $clog2(MAX_MS + 1);
    localparam logic [MS_W-1:0] NOTE_DUR = MS_W'(NOTE_MS);
    localparam logic [MS_W-1:0] GAP_DUR  = MS_W'(GAP_MS);

    logic [NUM_SOUNDS-1:0] req, req_q, rise;
    logic [NUM_SOUNDS-1:0] pending_q, pending_d, clear;

    state_t     state_q, state_d;
    logic       note_q, note_d;
    sound_id_t  cur_q, cur_d;
    logic       en_q, en_d;
    logic [3:0] freq_q, freq_d;
    logic       busy_q, busy_d;

    sound_id_t       pick;
    logic            do_start;
    logic            tmr_load;
    logic [MS_W-1:0] tmr_dur;
    logic            tmr_done;

    assign req = {keyYAudioRequest, keyXAudioRequest, keyEnterAudioRequest,
                  borderColAudioRequest, ballToBallColAudioRequest,
                  holeColAudioRequest};

    // A request counts once per low-to-high transition.
    assign rise = req & ~req_q;
    assign pick = lowest_pending(pending_q);

    // Decide whether a new sound starts this edge.
    always_comb begin
        do_start = (state_q == ST_IDLE) && (|pending_q);
`ifdef SOUND_PREEMPT_EN
        if ((state_q != ST_IDLE) && (|pending_q) && (pick < cur_q)) do_start = 1'b1;
`endif
    end

    // FSM next-state and registered-output values; also timer control.
    always_comb begin
        state_d  = state_q;
        note_d   = note_q;
        cur_d    = cur_q;
        en_d     = en_q;
        freq_d   = freq_q;
        busy_d   = busy_q;
        clear    = '0;
        tmr_load = 1'b0;
        tmr_dur  = NOTE_DUR;
        if (do_start) begin
            clear[pick] = 1'b1;
            state_d     = ST_PLAY;
            note_d      = 1'b0;
            cur_d       = pick;
            en_d        = 1'b1;
            freq_d      = NOTE_TBL[pick][0];
            busy_d      = 1'b1;
            tmr_load    = 1'b1;
            tmr_dur     = NOTE_DUR;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (tmr_done) begin
                        tmr_load = 1'b1;
                        if (!note_q) begin
                            note_d  = 1'b1;
                            freq_d  = NOTE_TBL[cur_q][1];
                            tmr_dur = NOTE_DUR;
                        end else begin
                            state_d = ST_GAP;
                            en_d    = 1'b0;
                            freq_d  = 4'd0;
                            tmr_dur = GAP_DUR;
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_done) begin
                        state_d = ST_IDLE;
                        note_d  = 1'b0;
                        cur_d   = SND_HOLE;
                        busy_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        // A fresh edge on the id just served re-arms it for a replay.
        pending_d = (pending_q & ~clear) | rise;
    end

    // All player state, edge-detect and pending registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            req_q     <= '0;
            pending_q <= '0;
            state_q   <= ST_IDLE;
            note_q    <= 1'b0;
            cur_q     <= SND_HOLE;
            en_q      <= 1'b0;
            freq_q    <= 4'd0;
            busy_q    <= 1'b0;
        end else begin
            req_q     <= req;
            pending_q <= pending_d;
            state_q   <= state_d;
            note_q    <= note_d;
            cur_q     <= cur_d;
            en_q      <= en_d;
            freq_q    <= freq_d;
            busy_q    <= busy_d;
        end
    end

    sound_ms_timer #(
        .CLKS_PER_MS (CLKS_PER_MS),
        .MS_W        (MS_W)
    ) u_timer (
        .clk    (clk),
        .resetN (resetN),
        .load   (tmr_load),
        .dur_ms (tmr_dur),
        .done   (tmr_done)
    );

    assign soundEnable  = en_q;
    assign freqIndex    = freq_q;
    assign currentSound = cur_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sound_request_player.sv
// Bench for sound_request_player with short timing (note 12, gap 4 cycles).
// The reference model tracks each sound as a start point plus elapsed
// cycles and derives the expected outputs from that offset.
module tb_sound_request_player;

    localparam int CLKS_PER_MS = 4;
    localparam int NOTE_MS     = 3;
    localparam int GAP_MS      = 1;
    localparam int NOTE_CYC    = CLKS_PER_MS * NOTE_MS;
    localparam int GAP_CYC     = CLKS_PER_MS * GAP_MS;
    localparam int SOUND_CYC   = 2 * NOTE_CYC + GAP_CYC;

    logic       clk = 1'b0;
    logic       resetN;
    logic [5:0] req = '0;
    logic       snd_en;
    logic [3:0] freq;
    logic [2:0] cur;
    logic       busy;

    always #5 clk = ~clk;

    sound_request_player #(
        .CLKS_PER_MS (CLKS_PER_MS),
        .NOTE_MS     (NOTE_MS),
        .GAP_MS      (GAP_MS)
    ) dut (
        .clk                       (clk),
        .resetN                    (resetN),
        .holeColAudioRequest       (req[0]),
        .ballToBallColAudioRequest (req[1]),
        .borderColAudioRequest     (req[2]),
        .keyEnterAudioRequest      (req[3]),
        .keyXAudioRequest          (req[4]),
        .keyYAudioRequest          (req[5]),
        .soundEnable               (snd_en),
        .freqIndex                 (freq),
        .currentSound              (cur),
        .busy                      (busy)
    );

    int n_vec  = 0;
    int n_miss = 0;

    int tbl0 [6] = '{9, 11, 6, 12, 8, 5};
    int tbl1 [6] = '{4, 11, 3, 7, 8, 5};

    // Reference model state.
    logic [5:0] m_prev = '0;
    logic [5:0] m_pend = '0;
    bit         m_play = 1'b0;
    int         m_id   = 0;
    int         m_off  = 0;

    // Observed statistics per scenario.
    int busy_cyc;
    int busy_rise;
    int f_cnt [16];
    bit busy_prev;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [5:0] p);
        for (int i = 0; i < 6; i++) if (p[i]) return i;
        return 0;
    endfunction

    // One clock edge of the reference model, using the inputs at that edge.
    task automatic model_step();
        logic [5:0] rise;
        int         low;
        bit         preempt;
        rise    = req & ~m_prev;
        low     = lowest(m_pend);
        preempt = 1'b0;
`ifdef SOUND_PREEMPT_EN
        preempt = m_play && (m_pend != 0) && (low < m_id);
`endif
        if (preempt || (!m_play && m_pend != 0)) begin
            m_pend[low] = 1'b0;
            m_play      = 1'b1;
            m_id        = low;
            m_off       = 0;
        end else if (m_play) begin
            m_off++;
            if (m_off == SOUND_CYC) m_play = 1'b0;
        end
        m_pend = m_pend | rise;
        m_prev = req;
    endtask

    task automatic check_outputs();
        int e_en, e_freq, e_cur, e_busy;
        e_en = 0; e_freq = 0; e_cur = 0; e_busy = 0;
        if (m_play) begin
            e_busy = 1;
            e_cur  = m_id;
            if (m_off < NOTE_CYC) begin
                e_en = 1; e_freq = tbl0[m_id];
            end else if (m_off < 2 * NOTE_CYC) begin
                e_en = 1; e_freq = tbl1[m_id];
            end
        end
        check_val("soundEnable", int'(snd_en), e_en);
        check_val("freqIndex", int'(freq), e_freq);
        check_val("currentSound", int'(cur), e_cur);
        check_val("busy", int'(busy), e_busy);
    endtask

    task automatic clr_stats();
        busy_cyc  = 0;
        busy_rise = 0;
        busy_prev = busy;
        for (int i = 0; i < 16; i++) f_cnt[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (busy) busy_cyc++;
        if (busy && !busy_prev) busy_rise++;
        busy_prev = busy;
        if (snd_en) f_cnt[freq]++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [5:0] mask);
        req = mask;
        tick();
        req = '0;
    endtask

    // Called at a point away from the clock edge; reset clears everything at once.
    task automatic apply_reset(input int cycles);
        resetN = 1'b0;
        req    = '0;
        m_prev = '0;
        m_pend = '0;
        m_play = 1'b0;
        m_id   = 0;
        m_off  = 0;
        #1;
        check_outputs();
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b1;
        #2;
        apply_reset(3);

        // 1: single hole pulse
        clr_stats();
        pulse(6'h01);
        run(40);
        check_val("t1_freq9_cycles", f_cnt[9], NOTE_CYC);
        check_val("t1_freq4_cycles", f_cnt[4], NOTE_CYC);
        check_val("t1_busy_cycles", busy_cyc, SOUND_CYC);

        // 2: all six at once
        clr_stats();
        pulse(6'h3F);
        run(6 * (SOUND_CYC + 1) + 10);
        check_val("t2_busy_cycles", busy_cyc, 6 * SOUND_CYC);
        check_val("t2_sounds", busy_rise, 6);

        // 3: keyX held high
        clr_stats();
        req = 6'h10;
        run(100);
        req = '0;
        run(40);
        check_val("t3_sounds", busy_rise, 1);
        check_val("t3_freq8_cycles", f_cnt[8], 2 * NOTE_CYC);

        // 4: border retriggered during note 0
        clr_stats();
        pulse(6'h04);
        run(6);
        pulse(6'h04);
        run(2 * SOUND_CYC + 10);
        check_val("t4_sounds", busy_rise, 2);
        check_val("t4_busy_cycles", busy_cyc, 2 * SOUND_CYC);

        // 5: keyY playing, hole arrives
        clr_stats();
        pulse(6'h20);
        run(3);
        pulse(6'h01);
        run(2 * SOUND_CYC + 10);
        check_val("t5_hole_played", f_cnt[4], NOTE_CYC);

        // 6: reset mid note 1 with enter pending
        pulse(6'h08);
        run(NOTE_CYC + 5);
        pulse(6'h08);
        run(2);
        apply_reset(2);
        clr_stats();
        run(40);
        check_val("t6_no_replay", busy_rise, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) req = 6'($urandom_range(0, 63));
            else if ($urandom_range(0, 3) == 0) req = '0;
            if ($urandom_range(0, 499) == 0) apply_reset($urandom_range(1, 3));
            else tick();
        end
        req = '0;
        run(6 * (SOUND_CYC + 1) + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
